// File: rtl/led_blink_pkg.sv
// Shared mode codes and burst FSM state encodings for the LED blink engine.
package led_blink_pkg;

    localparam int MODE_W = 4;

    localparam logic [MODE_W-1:0] MODE_OFF        = 4'd0;
    localparam logic [MODE_W-1:0] MODE_BLK_1HZ    = 4'd1;
    localparam logic [MODE_W-1:0] MODE_BLK_2HZ    = 4'd2;
    localparam logic [MODE_W-1:0] MODE_BLK_4HZ    = 4'd3;
    localparam logic [MODE_W-1:0] MODE_ON         = 4'd4;
    localparam logic [MODE_W-1:0] MODE_BURST_ONCE = 4'd5;
    localparam logic [MODE_W-1:0] MODE_BURST_RPT  = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_PAUSE,
        S_DONE
    } burst_state_t;

endpackage

// File: rtl/led_burst_ch.sv
// One LED channel: burst FSM plus the mode-to-lit mux. 'lit' is taken from
// the next state so the registered pin lines up with the FSM state register.
module led_burst_ch
    import led_blink_pkg::*;
#(
    parameter int BURST_LEN   = 3,
    parameter int PAUSE_TICKS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [2:0]        phase,
    input  logic [MODE_W-1:0] mode,
    input  logic              mode_change,
    output logic              lit,
    output logic              done
);

    localparam logic [3:0] LAST_BLINK = 4'(BURST_LEN);
    localparam logic [7:0] LAST_PAUSE = 8'(PAUSE_TICKS - 1);

    burst_state_t state, state_nxt;
    logic [3:0]   blink_cnt, blink_nxt;
    logic [7:0]   pause_cnt, pause_nxt;
    logic         is_burst;

    assign is_burst = (mode == MODE_BURST_ONCE) || (mode == MODE_BURST_RPT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            blink_cnt <= '0;
            pause_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_nxt;
            pause_cnt <= pause_nxt;
        end
    end

    // A mode change outranks a coincident tick: the burst restarts cleanly.
    always_comb begin
        state_nxt = state;
        blink_nxt = blink_cnt;
        pause_nxt = pause_cnt;
        if (!is_burst) begin
            state_nxt = S_IDLE;
            blink_nxt = '0;
            pause_nxt = '0;
        end else if (mode_change) begin
            state_nxt = S_ON;
            blink_nxt = '0;
            pause_nxt = '0;
        end else if (tick) begin
            case (state)
                S_ON: begin
                    state_nxt = S_OFF;
                    blink_nxt = blink_cnt + 4'd1;
                end
                S_OFF: begin
                    if (blink_cnt == LAST_BLINK) begin
                        if (mode == MODE_BURST_ONCE) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_PAUSE;
                            pause_nxt = '0;
                        end
                    end else begin
                        state_nxt = S_ON;
                    end
                end
                S_PAUSE: begin
                    if (pause_cnt == LAST_PAUSE) begin
                        state_nxt = S_ON;
                        blink_nxt = '0;
                    end else begin
                        pause_nxt = pause_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        lit = 1'b0;
        case (mode)
            MODE_BLK_1HZ:                    lit = ~phase[2];
            MODE_BLK_2HZ:                    lit = ~phase[1];
            MODE_BLK_4HZ:                    lit = ~phase[0];
            MODE_ON:                         lit = 1'b1;
            MODE_BURST_ONCE, MODE_BURST_RPT: lit = (state_nxt == S_ON);
            default:                         lit = 1'b0;
        endcase
    end

    assign done = (state == S_DONE);

endmodule

// File: rtl/led_blink_engine.sv
// N-channel LED pattern generator with a shared SYSCLK-derived timebase.
// Optional global PWM dimming is built when LED_PWM_DIM_EN is defined.
module led_blink_engine
    import led_blink_pkg::*;
#(
    parameter int NUM_CH      = 16,
    parameter int TICK_DIV    = 4125000,
    parameter int BURST_LEN   = 3,
    parameter int PAUSE_TICKS = 8,
    parameter int ACTIVE_LOW  = 0
`ifdef LED_PWM_DIM_EN
    ,
    parameter int PWM_BITS    = 4
`endif
) (
    input  logic                     SYSCLK,
    input  logic                     RESET,
    input  logic [NUM_CH*MODE_W-1:0] MODE,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_BITS-1:0]      DIM_LEVEL,
`endif
    output logic [NUM_CH-1:0]        LED,
    output logic [NUM_CH-1:0]        BURST_DONE,
    output logic                     TICK
);

    localparam int                PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [NUM_CH-1:0] OFF_LVL  = {NUM_CH{ACTIVE_LOW != 0}};

    logic [PRE_W-1:0]               presc;
    logic                           tick;
    logic [2:0]                     phase, phase_nxt;
    logic [NUM_CH-1:0][MODE_W-1:0]  mode_ch, mode_q;
    logic [NUM_CH-1:0]              lit;
    logic                           pwm_on;

    assign mode_ch   = MODE;
    assign tick      = (presc == PRE_LAST);
    assign phase_nxt = phase + {2'b00, tick};
    assign TICK      = tick;

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            presc  <= '0;
            phase  <= '0;
            mode_q <= '0;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            phase  <= phase_nxt;
            mode_q <= mode_ch;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign pwm_on = (pwm_cnt <= DIM_LEVEL);
`else
    assign pwm_on = 1'b1;
`endif

    // Channels see the post-edge phase so LED and phase change on the same edge.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        led_burst_ch #(
            .BURST_LEN   (BURST_LEN),
            .PAUSE_TICKS (PAUSE_TICKS)
        ) u_ch (
            .clk         (SYSCLK),
            .rst         (RESET),
            .tick        (tick),
            .phase       (phase_nxt),
            .mode        (mode_ch[k]),
            .mode_change (mode_ch[k] != mode_q[k]),
            .lit         (lit[k]),
            .done        (BURST_DONE[k])
        );
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) LED <= OFF_LVL;
        else       LED <= (lit & {NUM_CH{pwm_on}}) ^ OFF_LVL;
    end

endmodule

// File: tb/tb_led_blink_engine.sv
// Directed bench for led_blink_engine: NUM_CH=4, TICK_DIV=4, BURST_LEN=3,
// PAUSE_TICKS=4, plus an ACTIVE_LOW=1 instance for the polarity checks.
module tb_led_blink_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mode;
    logic [15:0] mode_al;
    logic [3:0]  led, led_al;
    logic [3:0]  burst_done, done_al;
    logic        tick, tick_al;
`ifdef LED_PWM_DIM_EN
    logic [3:0]  dim;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    led_blink_engine #(
        .NUM_CH(4), .TICK_DIV(4), .BURST_LEN(3), .PAUSE_TICKS(4), .ACTIVE_LOW(0)
    ) dut (
        .SYSCLK(clk), .RESET(rst), .MODE(mode),
`ifdef LED_PWM_DIM_EN
        .DIM_LEVEL(dim),
`endif
        .LED(led), .BURST_DONE(burst_done), .TICK(tick)
    );

    led_blink_engine #(
        .NUM_CH(4), .TICK_DIV(4), .BURST_LEN(3), .PAUSE_TICKS(4), .ACTIVE_LOW(1)
    ) dut_al (
        .SYSCLK(clk), .RESET(rst), .MODE(mode_al),
`ifdef LED_PWM_DIM_EN
        .DIM_LEVEL(dim),
`endif
        .LED(led_al), .BURST_DONE(done_al), .TICK(tick_al)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        mode = '0;
        mode_al = '0;
        repeat (3) step();
        #1 rst = 1'b0;
        mode[11:8] = 4'd5;
        repeat (10) step();
        // assert reset between edges to prove it is asynchronous
        #2 rst = 1'b1;
        #1;
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b want 0000", led); end
        checks++; if (burst_done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", burst_done); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
        checks++; if (led_al !== 4'b1111) begin errors++; $display("FAIL reset_led_al: got %b want 1111", led_al); end
        repeat (2) step();
        #1 rst = 1'b0;
        cyc = 0;
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_c1: got %b want 0", tick); end
        step(); step();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_c3: got %b want 0", tick); end
        step();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL tick_c4: got %b want 1", tick); end
        checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL burst_restart_after_reset: got %b want 1", led[2]); end
        mode = '0;
        step();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_c5: got %b want 0", tick); end
    endtask

    task automatic test_steady();
        logic e0, e1;
        mode = '0;
        while (cyc % 32 != 31) step();
        mode[3:0] = 4'd3;
        mode[7:4] = 4'd1;
        for (int j = 0; j < 32; j++) begin
            step();
            e0 = ((j / 4) % 2 == 0);
            e1 = (j < 16);
            checks++; if (led[0] !== e0) begin errors++; $display("FAIL steady_4hz j=%0d: got %b want %b", j, led[0], e0); end
            checks++; if (led[1] !== e1) begin errors++; $display("FAIL steady_1hz j=%0d: got %b want %b", j, led[1], e1); end
        end
        checks++; if (led[3:2] !== 2'b00) begin errors++; $display("FAIL steady_idle_ch: got %b want 00", led[3:2]); end
    endtask

    task automatic test_burst_once();
        logic e;
        mode = '0;
        step();
        while (cyc % 4 != 1) step();
        mode[11:8] = 4'd5;
        for (int k = 0; k < 22; k++) begin
            step();
            e = (k < 2) || (k >= 6 && k < 10) || (k >= 14 && k < 18);
            checks++; if (led[2] !== e) begin errors++; $display("FAIL once_led k=%0d: got %b want %b", k, led[2], e); end
            checks++; if (burst_done[2] !== 1'b0) begin errors++; $display("FAIL once_done_early k=%0d: got %b want 0", k, burst_done[2]); end
        end
        for (int k = 22; k < 122; k++) begin
            step();
            checks++; if (led[2] !== 1'b0 || burst_done[2] !== 1'b1) begin
                errors++; $display("FAIL once_hold k=%0d: got led=%b done=%b want led=0 done=1", k, led[2], burst_done[2]);
            end
        end
    endtask

    task automatic test_burst_rpt();
        logic e;
        mode = '0;
        step();
        checks++; if (burst_done[2] !== 1'b0) begin errors++; $display("FAIL done_clear: got %b want 0", burst_done[2]); end
        while (cyc % 4 != 1) step();
        mode[15:12] = 4'd6;
        for (int k = 0; k < 82; k++) begin
            step();
            e = (k < 2) || (k >= 6 && k < 10) || (k >= 14 && k < 18) ||
                (k >= 38 && k < 42) || (k >= 46 && k < 50) || (k >= 54 && k < 58) || (k >= 78);
            checks++; if (led[3] !== e) begin errors++; $display("FAIL rpt_led k=%0d: got %b want %b", k, led[3], e); end
            checks++; if (burst_done[3] !== 1'b0) begin errors++; $display("FAIL rpt_done k=%0d: got %b want 0", k, burst_done[3]); end
        end
    endtask

    task automatic test_restart_collision();
        mode = '0;
        step();
        while (cyc % 4 != 1) step();
        mode[11:8] = 4'd6;
        for (int k = 0; k <= 30; k++) begin
            step();
            if (k == 5) begin
                checks++; if (tick !== 1'b1 || led[2] !== 1'b0) begin
                    errors++; $display("FAIL coll_setup: got tick=%b led=%b want tick=1 led=0", tick, led[2]);
                end
                mode[11:8] = 4'd5;
            end
            if (k == 6) begin
                checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL coll_restart: got %b want 1", led[2]); end
            end
            if (k == 21) begin
                checks++; if (led[2] !== 1'b0 || burst_done[2] !== 1'b0) begin
                    errors++; $display("FAIL coll_k21: got led=%b done=%b want 0 0", led[2], burst_done[2]);
                end
            end
            if (k == 22) begin
                checks++; if (led[2] !== 1'b1 || burst_done[2] !== 1'b0) begin
                    errors++; $display("FAIL coll_third_blink: got led=%b done=%b want 1 0", led[2], burst_done[2]);
                end
            end
            if (k == 29) begin
                checks++; if (burst_done[2] !== 1'b0) begin errors++; $display("FAIL coll_k29_done: got %b want 0", burst_done[2]); end
            end
            if (k == 30) begin
                checks++; if (led[2] !== 1'b0 || burst_done[2] !== 1'b1) begin
                    errors++; $display("FAIL coll_done: got led=%b done=%b want 0 1", led[2], burst_done[2]);
                end
            end
        end
    endtask

    task automatic test_invalid_polarity();
        mode    = 16'h7F94;
        mode_al = 16'h0094;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (led !== 4'b0001) begin errors++; $display("FAIL invalid_led k=%0d: got %b want 0001", k, led); end
            checks++; if (led_al !== 4'b1110) begin errors++; $display("FAIL active_low k=%0d: got %b want 1110", k, led_al); end
        end
        checks++; if (burst_done !== 4'b0000) begin errors++; $display("FAIL invalid_done: got %b want 0000", burst_done); end
    endtask

    task automatic test_pwm();
`ifdef LED_PWM_DIM_EN
        int n;
        mode = '0;
        mode[3:0] = 4'd4;
        dim = 4'd3;
        repeat (2) step();
        n = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led[0]) n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL pwm_lit_count: got %0d want 4", n); end
        dim = 4'hF;
`endif
    endtask

    initial begin
`ifdef LED_PWM_DIM_EN
        dim = 4'hF;
`endif
        test_reset();
        test_steady();
        test_burst_once();
        test_burst_rpt();
        test_restart_collision();
        test_invalid_polarity();
        test_pwm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
